game_vga_scan: RTL
==================

GAME_VGA_SCAN -- requirements
Module: game_vga_scan

Interface
REQ-001 Parameter clk_mhz, default 50: system clock frequency in MHz.
REQ-002 Parameter pixel_mhz, default 25: pixel rate in MHz; clk_mhz SHALL be an integer multiple of pixel_mhz (ratio R = clk_mhz/pixel_mhz >= 1).
REQ-003 Parameter screen_width, default 640: visible pixels per line.
REQ-004 Parameter screen_height, default 480: visible lines per frame.
REQ-005 Parameter h_front, default 16: horizontal front porch in pixels.
REQ-006 Parameter h_sync, default 96: horizontal sync width in pixels.
REQ-007 Parameter h_back, default 48: horizontal back porch in pixels.
REQ-008 Parameter v_front, default 10: vertical front porch in lines.
REQ-009 Parameter v_sync, default 2: vertical sync width in lines.
REQ-010 Parameter v_back, default 33: vertical back porch in lines.
REQ-011 clk  input  1  system clock, all state on rising edge.
REQ-012 rst  input  1  reset, asynchronous, active-high.
REQ-013 x  output  $clog2(screen_width)  current visible column, to the pixel renderer.
REQ-014 y  output  $clog2(screen_height)  current visible line, to the pixel renderer.
REQ-015 display_on  output  1  high while the current (x,y) is in the visible area.
REQ-016 rgb_in  input  GAME_RGB_WIDTH  renderer colour for the current (x,y), combinational from x/y.
REQ-017 vga_rgb  output  GAME_RGB_WIDTH  registered colour to the display.
REQ-018 vga_hsync / vga_vsync  output  1 each  registered syncs, active-low.
REQ-019 pixel_en  output  1  one-clk strobe marking each pixel period.
REQ-020 frame_start  output  1  one-clk pulse at end of frame (see Configuration).

Function
REQ-021 Divider counts 0..R-1 on every clk and wraps; pixel_en = (divider == R-1); with R = 1, pixel_en is constantly high after reset.
REQ-022 H counter counts 0..H_TOTAL-1 (H_TOTAL = screen_width+h_front+h_sync+h_back = 800), advances only on pixel_en, wraps to 0.
REQ-023 V counter counts 0..V_TOTAL-1 (V_TOTAL = 525), advances on pixel_en when H = H_TOTAL-1, wraps to 0; internal counters SHALL be wide enough for H_TOTAL-1 and V_TOTAL-1, not limited to x/y widths.
REQ-024 display_on = (H < screen_width) and (V < screen_height), decoded combinationally from registered counters.
REQ-025 x/y = H/V truncated to port width when display_on, else 0.
REQ-026 Sync decode: hsync active for H in [screen_width+h_front, screen_width+h_front+h_sync), i.e. [656,752); vsync active for V in [490,492).
REQ-027 On pixel_en, output stage registers vga_rgb = display_on ? rgb_in : 0, plus both decoded syncs; the outputs are mutually aligned with a latency of exactly one pixel period after (x,y).
REQ-028 vga_rgb and the syncs hold their values between pixel_en strobes.
REQ-029 frame_start pulses for exactly one clk on pixel_en when H = H_TOTAL-1 and V = V_TOTAL-1, coinciding with the wrap to (0,0).
REQ-030 rgb_in is ignored outside the visible area, whatever its value.

Reset
REQ-031 On rst: divider, H and V = 0; vga_hsync = vga_vsync = 1; vga_rgb = 0; frame_start = 0; x = y = 0; display_on = 1; pixel_en = 0 (R > 1).
REQ-032 Reset asserted mid-frame aborts the frame immediately; after release, scanning restarts at (0,0) and the first pixel_en occurs R clks later.

Configuration
REQ-033 With macro GAME_VGA_FRAME_STROBE_EN defined, frame_start behaves per REQ-029.
REQ-034 Without GAME_VGA_FRAME_STROBE_EN, frame_start is tied 0 and the frame-end decode is not built; all other behaviour is unchanged.

Verification
REQ-035 Defaults, release reset -> pixel_en every 2 clk; H wraps 799->0 after 1600 clk; V increments to 1 at that wrap.
REQ-036 Run a line -> vga_hsync low for exactly 96 pixel periods (192 clk), starting one pixel after H = 656.
REQ-037 Run a frame -> vga_vsync low for exactly 2 lines (3200 clk), starting one pixel after (H = 0, V = 490).
REQ-038 rgb_in held all-ones -> vga_rgb all-ones for visible pixels, 0 when H >= 640 or V >= 480; x = y = 0 and display_on = 0 in blanking.
REQ-039 Macro defined -> frame_start pulses once every 840000 clk (800 x 525 x 2), width 1 clk; macro undefined -> frame_start stays 0.
REQ-040 Assert rst at V = 300, H = 400 -> all outputs at reset values within the same cycle; after release, H = V = 0 and normal timing resumes.

Source files
------------

// File: rtl/game_vga_scan.sv
// rtl/game_vga_scan.sv - VGA raster scan timing generator with registered colour/sync output stage.
// Optional frame-end strobe built only when GAME_VGA_FRAME_STROBE_EN is defined.
module game_vga_scan #(
    parameter int clk_mhz        = 50,
    parameter int pixel_mhz      = 25,
    parameter int screen_width   = 640,
    parameter int screen_height  = 480,
    parameter int h_front        = 16,
    parameter int h_sync         = 96,
    parameter int h_back         = 48,
    parameter int v_front        = 10,
    parameter int v_sync         = 2,
    parameter int v_back         = 33,
    parameter int GAME_RGB_WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [$clog2(screen_width)-1:0]   x,
    output logic [$clog2(screen_height)-1:0]  y,
    output logic                              display_on,
    input  logic [GAME_RGB_WIDTH-1:0]         rgb_in,
    output logic [GAME_RGB_WIDTH-1:0]         vga_rgb,
    output logic                              vga_hsync,
    output logic                              vga_vsync,
    output logic                              pixel_en,
    output logic                              frame_start
);

    localparam int R       = clk_mhz / pixel_mhz;
    localparam int DW      = (R > 1) ? $clog2(R) : 1;
    localparam int H_TOTAL = screen_width + h_front + h_sync + h_back;
    localparam int V_TOTAL = screen_height + v_front + v_sync + v_back;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(screen_width);
    localparam int YW      = $clog2(screen_height);

    localparam logic [DW-1:0] D_LAST   = DW'(R - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(screen_width);
    localparam logic [VW-1:0] V_VIS    = VW'(screen_height);
    localparam logic [HW-1:0] HS_START = HW'(screen_width + h_front);
    localparam logic [HW-1:0] HS_END   = HW'(screen_width + h_front + h_sync);
    localparam logic [VW-1:0] VS_START = VW'(screen_height + v_front);
    localparam logic [VW-1:0] VS_END   = VW'(screen_height + v_front + v_sync);

    logic [DW-1:0]             r_div;
    logic [HW-1:0]             r_h;
    logic [VW-1:0]             r_v;
    logic [GAME_RGB_WIDTH-1:0] r_rgb;
    logic                      r_hsync;
    logic                      r_vsync;

    logic w_pix_en;
    logic w_h_last;
    logic w_v_last;
    logic w_visible;
    logic w_hsync_act;
    logic w_vsync_act;

    assign w_pix_en    = (r_div == D_LAST);
    assign w_h_last    = (r_h == H_LAST);
    assign w_v_last    = (r_v == V_LAST);
    assign w_visible   = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hsync_act = (r_h >= HS_START) && (r_h < HS_END);
    assign w_vsync_act = (r_v >= VS_START) && (r_v < VS_END);

    // Clock divider: pixel_en marks the last clk of each pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_div == D_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_en) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Output stage: colour and syncs share one register so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_pix_en) begin
            r_rgb   <= w_visible ? rgb_in : '0;
            r_hsync <= ~w_hsync_act;
            r_vsync <= ~w_vsync_act;
        end
    end

`ifdef GAME_VGA_FRAME_STROBE_EN
    logic r_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_pix_en && w_h_last && w_v_last;
        end
    end

    assign frame_start = r_frame;
`else
    assign frame_start = 1'b0;
`endif

    assign pixel_en   = w_pix_en;
    assign display_on = w_visible;
    assign x          = w_visible ? r_h[XW-1:0] : '0;
    assign y          = w_visible ? r_v[YW-1:0] : '0;
    assign vga_rgb    = r_rgb;
    assign vga_hsync  = r_hsync;
    assign vga_vsync  = r_vsync;

endmodule
